// File: rtl/vga_pkg.sv
// 640x480@60 Hz raster timing constants and the coordinate type shared by the VGA timing
// generator.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam logic        VGA_SYNC_POL = 1'b0;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync windows are half-open: [start, end).
  localparam int unsigned VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int unsigned VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  function automatic int unsigned coord_width(input int unsigned h_total,
                                              input int unsigned v_total);
    return $clog2((h_total > v_total) ? h_total : v_total);
  endfunction

  localparam int unsigned VGA_CW = coord_width(VGA_H_TOTAL, VGA_V_TOTAL);

  typedef logic [VGA_CW-1:0] coord_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter that resets to its last value, so the first enabled edge after reset
// wraps to zero. Also exposes its next-state value for registered look-ahead decode.
module mod_counter #(
  parameter int unsigned MOD = 800,
  parameter int unsigned W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_run;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);
  assign wrap      = en && w_at_last;

  always_comb begin
    w_run = r_count;
    if (en) begin
      w_run = w_at_last ? '0 : r_count + W'(1);
    end
  end

  assign count_next = rst ? LAST : w_run;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= LAST;
    end else begin
      r_count <= w_run;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates plus sync, blanking and frame/line markers,
// all registered together so every output describes the same raster position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        SYNC_POL = VGA_SYNC_POL,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned CW      = coord_width(H_TOTAL, V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          frame_start,
  output logic          line_end
);

  localparam logic [CW-1:0] HA       = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA       = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);

  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;
  logic          w_h_wrap;
  logic          w_v_wrap;

  logic r_hsync;
  logic r_vsync;
  logic r_video_on;
  logic r_frame_start;
  logic r_line_end;

  mod_counter #(
    .MOD (H_TOTAL),
    .W   (CW)
  ) u_h_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (1'b1),
    .count      (pixel_x),
    .count_next (w_x_next),
    .wrap       (w_h_wrap)
  );

  mod_counter #(
    .MOD (V_TOTAL),
    .W   (CW)
  ) u_v_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (w_h_wrap),
    .count      (pixel_y),
    .count_next (w_y_next),
    .wrap       (w_v_wrap)
  );

  // Decoding the counters' next state lets these flops line up with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b1;
    end else begin
      r_hsync       <= ((w_x_next >= HS_START) && (w_x_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= ((w_y_next >= VS_START) && (w_y_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= (w_x_next < HA) && (w_y_next < VA);
      r_frame_start <= (w_x_next == '0) && (w_y_next == '0);
      r_line_end    <= (w_x_next == H_LAST);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;
  assign line_end    = r_line_end;

  logic w_unused;
  assign w_unused = w_v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance and a tiny-raster instance
// share one pixel clock; directed expectations are queued per instance and checked by a monitor.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // flags = {hsync, vsync, video_on, frame_start, line_end}
  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic [4:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst_b, rst_s;
  logic       b_hs, b_vs, b_von, b_fs, b_le;
  logic [9:0] b_x, b_y;
  logic       s_hs, s_vs, s_von, s_fs, s_le;
  logic [3:0] s_x, s_y;

  vga_timing_gen u_dut_big (
    .clk         (clk),
    .rst         (rst_b),
    .hsync       (b_hs),
    .vsync       (b_vs),
    .video_on    (b_von),
    .pixel_x     (b_x),
    .pixel_y     (b_y),
    .frame_start (b_fs),
    .line_end    (b_le)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1)
  ) u_dut_sml (
    .clk         (clk),
    .rst         (rst_s),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .video_on    (s_von),
    .pixel_x     (s_x),
    .pixel_y     (s_y),
    .frame_start (s_fs),
    .line_end    (s_le)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q_b[$];
  exp_t q_s[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input bit sml, input int c, input string nm, input int x, input int y,
                      input logic [4:0] f);
    exp_t e;
    e.cyc   = c;
    e.name  = nm;
    e.x     = 16'(x);
    e.y     = 16'(y);
    e.flags = f;
    if (sml) q_s.push_back(e);
    else     q_b.push_back(e);
  endtask

  task automatic compare(input exp_t e, input logic [15:0] ax, input logic [15:0] ay,
                         input logic [4:0] af);
    n_cmp++;
    if (ax !== e.x || ay !== e.y || af !== e.flags || e.cyc != cyc) begin
      n_bad++;
      $display("FAIL %s @cyc %0d (due %0d): got x=%0d y=%0d {hs,vs,von,fs,le}=%b, want x=%0d y=%0d %b",
               e.name, cyc, e.cyc, ax, ay, af, e.x, e.y, e.flags);
    end
  endtask

  // Scoreboard monitor: pops an expectation when its cycle comes due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_b.size() != 0 && q_b[0].cyc <= cyc) begin
        e = q_b.pop_front();
        compare(e, 16'(b_x), 16'(b_y), {b_hs, b_vs, b_von, b_fs, b_le});
      end
      if (q_s.size() != 0 && q_s[0].cyc <= cyc) begin
        e = q_s.pop_front();
        compare(e, 16'(s_x), 16'(s_y), {s_hs, s_vs, s_von, s_fs, s_le});
      end
    end
  end

  // Small raster: measure the first full frame between two frame_start pulses.
  bit   f_done   = 1'b0;
  int   fs_seen  = 0;
  int   f_first  = 0;
  int   hs_falls = 0;
  int   vs_cyc   = 0;
  logic hs_prev  = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      if (!f_done) begin
        if (s_fs === 1'b1) begin
          if (fs_seen == 1) begin
            n_cmp += 3;
            if (cyc - f_first != 105) begin
              n_bad++;
              $display("FAIL sml_frame_period: got %0d clocks, want 105", cyc - f_first);
            end
            if (hs_falls != 7) begin
              n_bad++;
              $display("FAIL sml_hsync_pulses: got %0d per frame, want 7", hs_falls);
            end
            if (vs_cyc != 15) begin
              n_bad++;
              $display("FAIL sml_vsync_width: got %0d clocks, want 15", vs_cyc);
            end
            f_done = 1'b1;
          end
          fs_seen++;
          f_first  = cyc;
          hs_falls = 0;
          vs_cyc   = 0;
        end
        if (fs_seen >= 1) begin
          if (s_hs === 1'b0 && hs_prev === 1'b1) hs_falls++;
          if (s_vs === 1'b0) vs_cyc++;
        end
        hs_prev = s_hs;
      end
    end
  end

  int base;
  initial begin
    rst_b = 1'b1;
    rst_s = 1'b1;
    for (int c = 1; c <= 3; c++) push(0, c, "big_reset_held", 799, 524, 5'b11001);
    push(1, 3, "sml_reset_held", 14, 6, 5'b11001);
    repeat (3) @(negedge clk);

    rst_b = 1'b0;
    base  = cyc + 1;
    push(0, base + 0,     "big_first_pixel",  0,   0,  5'b11110);
    push(0, base + 1,     "big_x1",           1,   0,  5'b11100);
    push(0, base + 639,   "big_last_visible", 639, 0,  5'b11100);
    push(0, base + 640,   "big_blank_start",  640, 0,  5'b11000);
    push(0, base + 655,   "big_fp_end",       655, 0,  5'b11000);
    push(0, base + 656,   "big_hsync_start",  656, 0,  5'b01000);
    push(0, base + 751,   "big_hsync_end",    751, 0,  5'b01000);
    push(0, base + 752,   "big_bp_start",     752, 0,  5'b11000);
    push(0, base + 798,   "big_x798",         798, 0,  5'b11000);
    push(0, base + 799,   "big_line_end",     799, 0,  5'b11001);
    push(0, base + 800,   "big_line1",        0,   1,  5'b11100);
    push(0, base + 1599,  "big_line1_end",    799, 1,  5'b11001);
    push(0, base + 1600,  "big_line2",        0,   2,  5'b11100);
    push(0, base + 16300, "big_mid_frame",    300, 20, 5'b11100);
    while (cyc < base + 16300) @(negedge clk);

    rst_b = 1'b1;
    push(0, cyc + 1, "big_mid_reset", 799, 524, 5'b11001);
    @(negedge clk);
    rst_b = 1'b0;
    push(0, cyc + 1, "big_restart",    0, 0, 5'b11110);
    push(0, cyc + 2, "big_restart_x1", 1, 0, 5'b11100);

    repeat (3) @(negedge clk);
    push(1, cyc + 1, "sml_reset_long", 14, 6, 5'b11001);
    @(negedge clk);
    rst_s = 1'b0;
    base  = cyc + 1;
    push(1, base + 0,   "sml_first_pixel",  0,  0, 5'b11110);
    push(1, base + 7,   "sml_last_visible", 7,  0, 5'b11100);
    push(1, base + 8,   "sml_blank_start",  8,  0, 5'b11000);
    push(1, base + 9,   "sml_fp",           9,  0, 5'b11000);
    push(1, base + 10,  "sml_hsync_start",  10, 0, 5'b01000);
    push(1, base + 12,  "sml_hsync_end",    12, 0, 5'b01000);
    push(1, base + 13,  "sml_bp",           13, 0, 5'b11000);
    push(1, base + 14,  "sml_line_end",     14, 0, 5'b11001);
    push(1, base + 15,  "sml_line1",        0,  1, 5'b11100);
    push(1, base + 60,  "sml_vblank_line",  0,  4, 5'b11000);
    push(1, base + 74,  "sml_vblank_end",   14, 4, 5'b11001);
    push(1, base + 75,  "sml_vsync_start",  0,  5, 5'b10000);
    push(1, base + 85,  "sml_both_sync",    10, 5, 5'b00000);
    push(1, base + 89,  "sml_vsync_end",    14, 5, 5'b10001);
    push(1, base + 90,  "sml_vbp",          0,  6, 5'b11000);
    push(1, base + 104, "sml_frame_last",   14, 6, 5'b11001);
    push(1, base + 105, "sml_frame_wrap",   0,  0, 5'b11110);
    push(1, base + 110, "sml_frame2_x5",    5,  0, 5'b11100);
    push(1, base + 128, "sml_mid_frame",    8,  1, 5'b11000);
    while (cyc < base + 128) @(negedge clk);

    rst_s = 1'b1;
    push(1, cyc + 1, "sml_mid_reset", 14, 6, 5'b11001);
    @(negedge clk);
    rst_s = 1'b0;
    push(1, cyc + 1, "sml_restart", 0, 0, 5'b11110);

    repeat (5) @(negedge clk);
    n_cmp++;
    if (q_b.size() + q_s.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q_b.size() + q_s.size());
    end
    n_cmp++;
    if (!f_done) begin
      n_bad++;
      $display("FAIL sml_frame_measure: got %0d frame_start pulses, want 2", fs_seen);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
